pipe_stage_reg: RTL and testbench

- Parametrised pipeline stage register; next generation of the fixed D/E-style stage registers.
- Carries one opaque payload plus a PC field between two pipeline stages.
- Adds a valid/ready handshake, an optional 1-entry skid buffer, synchronous flush with optional PC retention for bubbles, and saturating stall/bubble performance counters.
- One instance per stage boundary (F/D, D/E, E/M, M/W).

---
 rtl/pipe_stage_reg.sv | 156 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register with valid/ready handshake.
//   Carries one PC field and one opaque payload between two pipeline stages.
//   SKID=1 adds a one-entry skid register so in_ready can come from a flop;
//   SKID=0 is a single register with combinational in_ready.
//   Supports synchronous flush (optionally retaining in_pc for the bubble) and
//   saturating stall/bubble performance counters.
// Ports:
//   clk, reset               rising-edge clock, synchronous active-high reset
//   in_valid/in_ready        upstream handshake, in_pc/in_payload upstream data
//   flush, flush_keep_pc     kill held/incoming entries; optionally keep in_pc
//   out_valid/out_ready      downstream handshake, out_pc/out_payload held data
//   stall_cnt, bubble_cnt    saturating performance counters
module pipe_stage_reg #(
   parameter int unsigned PAYLOAD_W = 197,
   parameter int unsigned PC_W      = 32,
   parameter int unsigned SKID      = 1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PC_W-1:0]      in_pc,
   input  logic [PAYLOAD_W-1:0] in_payload,
   input  logic                 flush,
   input  logic                 flush_keep_pc,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PC_W-1:0]      out_pc,
   output logic [PAYLOAD_W-1:0] out_payload,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     bubble_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [PC_W-1:0]        pc_q, pc_d;
   logic [PAYLOAD_W-1:0]   pl_q, pl_d;
   logic [PC_W-1:0]        skpc_q, skpc_d;
   logic [PAYLOAD_W-1:0]   skpl_q, skpl_d;
   logic [CNT_W-1:0]       stall_q, bubble_q;
   logic                   accept, drain;

   assign accept = in_valid & in_ready;
   assign drain  = out_valid & out_ready;

   generate
      if (SKID != 0) begin : g_skid
         logic rdy_q;
         // Registered ready: reflects whether the state after this edge is SKID.
         always_ff @(posedge clk) begin
            if (reset) rdy_q <= 1'b1;
            else       rdy_q <= (state_d != ST_SKID);
         end
         assign in_ready = rdy_q;
      end else begin : g_noskid
         assign in_ready = ~out_valid | out_ready;
      end
   endgenerate

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_EMPTY;
         pc_q    <= '0;
         pl_q    <= '0;
         skpc_q  <= '0;
         skpl_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pl_q    <= pl_d;
         skpc_q  <= skpc_d;
         skpl_q  <= skpl_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pl_d    = pl_q;
      skpc_d  = skpc_q;
      skpl_d  = skpl_q;
      if (flush) begin
         state_d = ST_EMPTY;
         pc_d    = flush_keep_pc ? in_pc : '0;
         pl_d    = '0;
         skpc_d  = '0;
         skpl_d  = '0;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  state_d = ST_FULL;
                  pc_d    = in_pc;
                  pl_d    = in_payload;
               end
            end
            ST_FULL: begin
               if (accept && drain) begin
                  pc_d = in_pc;
                  pl_d = in_payload;
               end else if (accept && (SKID != 0)) begin
                  state_d = ST_SKID;
                  skpc_d  = in_pc;
                  skpl_d  = in_payload;
               end else if (drain) begin
                  state_d = ST_EMPTY;
                  pc_d    = '0;
                  pl_d    = '0;
               end
            end
            ST_SKID: begin
               if (drain) begin
                  state_d = ST_FULL;
                  pc_d    = skpc_q;
                  pl_d    = skpl_q;
                  skpc_d  = '0;
                  skpl_d  = '0;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   // Output logic; main payload is zeroed whenever the stage empties.
   always_comb begin
      out_valid   = (state_q != ST_EMPTY);
      out_pc      = pc_q;
      out_payload = pl_q;
   end

   // Counters use pre-edge outputs and stick at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q  <= '0;
         bubble_q <= '0;
      end else begin
         if (out_valid && !out_ready && (stall_q != '1))
            stall_q <= stall_q + 1'b1;
         if (!out_valid && (bubble_q != '1))
            bubble_q <= bubble_q + 1'b1;
      end
   end

   assign stall_cnt  = stall_q;
   assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

   logic         clk = 1'b0;
   logic         reset, in_valid, flush, flush_keep_pc, out_ready;
   logic [31:0]  in_pc;
   logic [196:0] in_payload;

   logic         v0, r0, v1, r1;
   logic [31:0]  pc0, pc1;
   logic [196:0] pl0, pl1;
   logic [15:0]  st0, bb0;
   logic [3:0]   st1, bb1;

   int unsigned total = 0;
   int unsigned bad   = 0;
   bit          chk_en = 1'b0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.PAYLOAD_W(197), .PC_W(32), .SKID(1), .CNT_W(16)) u0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r0),
      .in_pc(in_pc), .in_payload(in_payload), .flush(flush),
      .flush_keep_pc(flush_keep_pc), .out_valid(v0), .out_ready(out_ready),
      .out_pc(pc0), .out_payload(pl0), .stall_cnt(st0), .bubble_cnt(bb0));

   pipe_stage_reg #(.PAYLOAD_W(197), .PC_W(32), .SKID(0), .CNT_W(4)) u1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r1),
      .in_pc(in_pc), .in_payload(in_payload), .flush(flush),
      .flush_keep_pc(flush_keep_pc), .out_valid(v1), .out_ready(out_ready),
      .out_pc(pc1), .out_payload(pl1), .stall_cnt(st1), .bubble_cnt(bb1));

   function automatic logic [196:0] mkpl(input logic [31:0] pc);
      return {5'h1B, pc, ~pc, pc ^ 32'h5A5A5A5A, pc + 32'd1,
              {pc[15:0], pc[31:16]}, 32'hC0DE0000 | pc};
   endfunction

   // Model: each instance is a FIFO of capacity 2 (skid) or 1 (no skid).
   logic [31:0]  m_pc  [2][2];
   logic [196:0] m_pl  [2][2];
   int           m_n   [2];
   logic [31:0]  m_epc [2];
   int unsigned  m_st  [2];
   int unsigned  m_bb  [2];

   function automatic int unsigned m_max(input int k);
      return (k == 0) ? 65535 : 15;
   endfunction

   function automatic bit m_rdy(input int k);
      if (k == 0) return (m_n[k] < 2);
      return (m_n[k] == 0) || out_ready;
   endfunction

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         bit v, acc, drn;
         v   = (m_n[k] > 0);
         acc = in_valid && m_rdy(k);
         drn = v && out_ready;
         if (reset) begin
            m_n[k] = 0; m_epc[k] = '0; m_st[k] = 0; m_bb[k] = 0;
         end else begin
            if (v && !out_ready && m_st[k] < m_max(k)) m_st[k]++;
            if (!v && m_bb[k] < m_max(k)) m_bb[k]++;
            if (flush) begin
               m_n[k]   = 0;
               m_epc[k] = flush_keep_pc ? in_pc : '0;
            end else begin
               if (drn) begin
                  m_pc[k][0] = m_pc[k][1];
                  m_pl[k][0] = m_pl[k][1];
                  m_n[k]--;
                  if (m_n[k] == 0) m_epc[k] = '0;
               end
               if (acc) begin
                  m_pc[k][m_n[k]] = in_pc;
                  m_pl[k][m_n[k]] = in_payload;
                  m_n[k]++;
               end
            end
         end
      end
   endtask

   task automatic chk(input string nm, input logic [196:0] act, input logic [196:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      chk_en = 1'b1;
      #1;
   endtask

   task automatic drive(input bit v, input logic [31:0] pc);
      in_valid   = v;
      in_pc      = pc;
      in_payload = mkpl(pc);
   endtask

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            bit           dv, dr;
            logic [31:0]  dpc;
            logic [196:0] dpl;
            logic [15:0]  dst, dbb;
            bit           ev;
            dv  = (k == 0) ? v0 : v1;
            dr  = (k == 0) ? r0 : r1;
            dpc = (k == 0) ? pc0 : pc1;
            dpl = (k == 0) ? pl0 : pl1;
            dst = (k == 0) ? st0 : {12'd0, st1};
            dbb = (k == 0) ? bb0 : {12'd0, bb1};
            ev  = (m_n[k] > 0);
            chk($sformatf("u%0d.valid", k), dv, ev);
            chk($sformatf("u%0d.ready", k), dr, m_rdy(k));
            chk($sformatf("u%0d.pc", k), dpc, ev ? m_pc[k][0] : m_epc[k]);
            chk($sformatf("u%0d.payload", k), dpl, ev ? m_pl[k][0] : '0);
            chk($sformatf("u%0d.stall", k), dst, m_st[k]);
            chk($sformatf("u%0d.bubble", k), dbb, m_bb[k]);
            if (!dv) chk($sformatf("u%0d.idle_zero", k), dpl, '0);
         end
      end
   end

   initial begin
      reset = 1'b1; flush = 1'b0; flush_keep_pc = 1'b0; out_ready = 1'b1;
      drive(1'b0, 32'h0);
      tick(); tick();
      reset = 1'b0;
      repeat (5) tick();
      chk("idle.bubble", bb0, 16'd5);
      chk("idle.stall", st0, 16'd0);
      chk("idle.valid", v0, 1'b0);
      chk("idle.ready", r0, 1'b1);
      chk("idle.payload", pl0, '0);

      // Back-to-back stream
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h3000 + 32'(4 * i));
         tick();
         chk("stream.pc", pc0, 32'h3000 + 32'(4 * i));
         chk("stream.valid", v0, 1'b1);
      end
      drive(1'b0, 32'h0);
      tick();
      chk("stream.nostall", st0, 16'd0);

      // Fill skid, then drain in order
      out_ready = 1'b0;
      drive(1'b1, 32'h3000); tick();
      drive(1'b1, 32'h3004); tick();
      drive(1'b0, 32'h0);    tick();
      chk("skid.ready", r0, 1'b0);
      chk("skid.pc", pc0, 32'h3000);
      chk("skid.stall", st0, 16'd2);
      out_ready = 1'b1;
      tick();
      chk("skid.drain2", pc0, 32'h3004);
      tick();
      chk("skid.empty", v0, 1'b0);

      // Flush while in SKID state, keeping the PC
      out_ready = 1'b0;
      drive(1'b1, 32'h3000); tick();
      drive(1'b1, 32'h3004); tick();
      drive(1'b1, 32'h3010); flush = 1'b1; flush_keep_pc = 1'b1;
      tick();
      flush = 1'b0; flush_keep_pc = 1'b0; drive(1'b0, 32'h0);
      chk("flush.valid", v0, 1'b0);
      chk("flush.pc", pc0, 32'h3010);
      chk("flush.ready", r0, 1'b1);
      out_ready = 1'b1;
      repeat (3) tick();

      // Flush coincident with an accept
      drive(1'b1, 32'h3020); flush = 1'b1; tick();
      flush = 1'b0;
      chk("flushacc.valid", v0, 1'b0);
      chk("flushacc.pc", pc0, 32'h0);
      drive(1'b1, 32'h3024); tick();
      chk("after.pc", pc0, 32'h3024);
      drive(1'b0, 32'h0); tick();

      // Randomised traffic, checked by the model each cycle
      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom_range(0, 1)), {$urandom_range(0, 32'h3FFF), 2'b00});
         out_ready     = 1'($urandom_range(0, 2) != 0);
         flush         = ($urandom_range(0, 15) == 0);
         flush_keep_pc = 1'($urandom_range(0, 1));
         tick();
      end
      flush = 1'b0; drive(1'b0, 32'h0);

      // Saturation on the 4-bit counter instance, then reset mid-stall
      reset = 1'b1; tick();
      reset = 1'b0; out_ready = 1'b0;
      drive(1'b1, 32'h3030); tick();
      drive(1'b0, 32'h0);
      repeat (20) tick();
      chk("sat.stall", st1, 4'd15);
      reset = 1'b1; tick();
      chk("rst.valid", v1, 1'b0);
      chk("rst.pc", pc1, 32'h0);
      chk("rst.payload", pl1, '0);
      chk("rst.stall", st1, 4'd0);
      chk("rst.bubble", bb1, 4'd0);
      reset = 1'b0; tick();

      @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
